// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS memory stage: access sizes and FSM states.
package mips_pkg;

    // Access size encodings as carried on MEM_Size (3 behaves like word).
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Memory-access FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port. Handshake: the stage holds dmem_req=1 with stable
// addr/be/we/wdata until the memory answers with dmem_ready=1 in the same
// cycle; that cycle completes the access and dmem_rdata is valid only then.
// A request may be abandoned (reset or timeout) without ever seeing ready.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the addressed byte/half out of a read word and extends it.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane selection by low address bits, then sign/zero extension by size.
    always_comb begin
        lane_b = rdata[7:0];
        lane_h = rdata[15:0];
        result = rdata;
        case (a)
            2'd0: lane_b = rdata[7:0];
            2'd1: lane_b = rdata[15:8];
            2'd2: lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        if (a[1]) lane_h = rdata[31:16];
        case (size)
            SZ_BYTE: result = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: result = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage with MEM/WB register: drives a variable-latency data
// memory, stalls upstream while waiting, aborts after TIMEOUT wait cycles.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] MEM_D1,
    input  logic [31:0] MEM_D2,
    input  logic [4:0]  MEM_RD,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Size,
    input  logic        MEM_Unsigned,
    mem_stage_if.master bus,
    output logic        mem_stall,
    output logic [31:0] WB_Data,
    output logic [4:0]  WB_RD,
    output logic        WB_RegWrite,
    output logic        WB_Misalign,
    output logic        WB_BusErr,
    output mem_state_t  dbg_state
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    mem_state_t  state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        access, misaligned, abort, complete;
    logic        is_byte, is_half, is_word;
    logic [31:0] load_data;
    logic [31:0] wb_data_nx;
    logic        wb_regwrite_nx, wb_misalign_nx, wb_buserr_nx;

    assign is_byte    = (MEM_Size == SZ_BYTE);
    assign is_half    = (MEM_Size == SZ_HALF);
    assign is_word    = !is_byte && !is_half;
    assign access     = MEM_MemRead | MEM_MemWrite;
    assign misaligned = (is_half & MEM_D1[0]) | (is_word & (MEM_D1[1:0] != 2'b00));
    assign dbg_state  = state;

    // Lane steering; recomputed each cycle from the held EX/MEM inputs.
    always_comb begin
        bus.dmem_we    = MEM_MemWrite;
        bus.dmem_addr  = {MEM_D1[31:2], 2'b00};
        bus.dmem_be    = 4'b1111;
        bus.dmem_wdata = MEM_D2;
        if (is_byte) begin
            bus.dmem_be    = 4'b0001 << MEM_D1[1:0];
            bus.dmem_wdata = {4{MEM_D2[7:0]}};
        end else if (is_half) begin
            bus.dmem_be    = MEM_D1[1] ? 4'b1100 : 4'b0011;
            bus.dmem_wdata = {2{MEM_D2[15:0]}};
        end
    end

    // FSM next state, request and wait counter; reset low forces the request off.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bus.dmem_req = 1'b0;
        abort        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access && !misaligned && reset) begin
                    bus.dmem_req = 1'b1;
                    if (!bus.dmem_ready) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                bus.dmem_req = reset;
                if (bus.dmem_ready) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 8'd0;
                end else if (cnt == TIMEOUT_CNT) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    assign mem_stall = bus.dmem_req & ~bus.dmem_ready & ~abort;
    assign complete  = bus.dmem_req & bus.dmem_ready;

    load_align u_load_align (
        .rdata  (bus.dmem_rdata),
        .a      (MEM_D1[1:0]),
        .size   (MEM_Size),
        .uns    (MEM_Unsigned),
        .result (load_data)
    );

    // Next MEM/WB contents: bubble while stalled, flags on abort/misalign.
    always_comb begin
        wb_data_nx     = MEM_D1;
        wb_regwrite_nx = 1'b0;
        wb_misalign_nx = 1'b0;
        wb_buserr_nx   = 1'b0;
        if (mem_stall) begin
            wb_regwrite_nx = 1'b0;
        end else if (abort) begin
            wb_buserr_nx = 1'b1;
        end else if (access && misaligned) begin
            wb_misalign_nx = 1'b1;
        end else if (complete && MEM_MemRead) begin
            wb_data_nx     = load_data;
            wb_regwrite_nx = MEM_RegWrite;
        end else if (!access) begin
            wb_regwrite_nx = MEM_RegWrite;
        end
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            WB_Data     <= 32'd0;
            WB_RD       <= 5'd0;
            WB_RegWrite <= 1'b0;
            WB_Misalign <= 1'b0;
            WB_BusErr   <= 1'b0;
        end else begin
            WB_Data     <= wb_data_nx;
            WB_RD       <= MEM_RD;
            WB_RegWrite <= wb_regwrite_nx;
            WB_Misalign <= wb_misalign_nx;
            WB_BusErr   <= wb_buserr_nx;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, loads, stalled store,
// misalignment, timeout abort, reset mid-wait and back-to-back accesses.
module tb_mem_stage;
    import mips_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] MEM_D1, MEM_D2;
    logic [4:0]  MEM_RD;
    logic        MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_Unsigned;
    logic [1:0]  MEM_Size;
    logic        mem_stall;
    logic [31:0] WB_Data;
    logic [4:0]  WB_RD;
    logic        WB_RegWrite, WB_Misalign, WB_BusErr;
    mem_state_t  dbg_state;

    int errors = 0;
    int checks = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .MEM_D1       (MEM_D1),
        .MEM_D2       (MEM_D2),
        .MEM_RD       (MEM_RD),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_Size     (MEM_Size),
        .MEM_Unsigned (MEM_Unsigned),
        .bus          (bus),
        .mem_stall    (mem_stall),
        .WB_Data      (WB_Data),
        .WB_RD        (WB_RD),
        .WB_RegWrite  (WB_RegWrite),
        .WB_Misalign  (WB_Misalign),
        .WB_BusErr    (WB_BusErr),
        .dbg_state    (dbg_state)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw,
                          input logic [1:0] sz, input logic uns);
        MEM_D1 = d1; MEM_D2 = d2; MEM_RD = rd; MEM_RegWrite = rw;
        MEM_MemRead = mr; MEM_MemWrite = mw; MEM_Size = sz; MEM_Unsigned = uns;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_op(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0);
        bus.dmem_rdata = 32'd0;
        bus.dmem_ready = 1'b0;
        #2;
        check("rst_wb_data", WB_Data, 32'd0);
        check("rst_wb_rd", 32'(WB_RD), 32'd0);
        check("rst_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("rst_wb_misalign", 32'(WB_Misalign), 32'd0);
        check("rst_wb_buserr", 32'(WB_BusErr), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clock);
        reset = 1'b1;

        // ALU op pass-through
        set_op(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0);
        #1;
        check("alu_req", 32'(bus.dmem_req), 32'd0);
        check("alu_stall", 32'(mem_stall), 32'd0);
        tick();
        check("alu_wb_data", WB_Data, 32'h1234);
        check("alu_wb_rd", 32'(WB_RD), 32'd5);
        check("alu_wb_regwrite", 32'(WB_RegWrite), 32'd1);

        // LB at 0x1003, ready same cycle
        set_op(32'h1003, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b0);
        bus.dmem_rdata = 32'h80FF_FFFF;
        bus.dmem_ready = 1'b1;
        #1;
        check("lb_req", 32'(bus.dmem_req), 32'd1);
        check("lb_stall", 32'(mem_stall), 32'd0);
        check("lb_addr", bus.dmem_addr, 32'h1000);
        check("lb_be", 32'(bus.dmem_be), 32'h8);
        check("lb_we", 32'(bus.dmem_we), 32'd0);
        tick();
        check("lb_wb_data", WB_Data, 32'hFFFF_FF80);
        check("lb_wb_rd", 32'(WB_RD), 32'd7);
        check("lb_wb_regwrite", 32'(WB_RegWrite), 32'd1);

        // LBU, same access
        MEM_Unsigned = 1'b1;
        #1;
        check("lbu_stall", 32'(mem_stall), 32'd0);
        tick();
        check("lbu_wb_data", WB_Data, 32'h0000_0080);

        // SH at 0x2002, three wait cycles
        set_op(32'h2002, 32'hCAFE_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, SZ_HALF, 1'b0);
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sh_stall", 32'(mem_stall), 32'd1);
            check("sh_req", 32'(bus.dmem_req), 32'd1);
            check("sh_be", 32'(bus.dmem_be), 32'hC);
            check("sh_wdata", bus.dmem_wdata, 32'hBEEF_BEEF);
            check("sh_addr", bus.dmem_addr, 32'h2000);
            check("sh_we", 32'(bus.dmem_we), 32'd1);
            tick();
            check("sh_wb_regwrite_stall", 32'(WB_RegWrite), 32'd0);
            check("sh_state_wait", 32'(dbg_state), 32'(ST_WAIT));
        end
        bus.dmem_ready = 1'b1;
        #1;
        check("sh_done_stall", 32'(mem_stall), 32'd0);
        check("sh_done_req", 32'(bus.dmem_req), 32'd1);
        tick();
        check("sh_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("sh_wb_buserr", 32'(WB_BusErr), 32'd0);
        check("sh_state_idle", 32'(dbg_state), 32'(ST_IDLE));

        // Misaligned LW at 0x3001
        set_op(32'h3001, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
        #1;
        check("mis_req", 32'(bus.dmem_req), 32'd0);
        check("mis_stall", 32'(mem_stall), 32'd0);
        tick();
        check("mis_wb_misalign", 32'(WB_Misalign), 32'd1);
        check("mis_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        set_op(32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0);
        tick();
        check("mis_wb_misalign_clear", 32'(WB_Misalign), 32'd0);

        // LW timing out (TIMEOUT=4)
        set_op(32'h4000, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
        bus.dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_stall", 32'(mem_stall), 32'd1);
            tick();
            check("to_wb_buserr_wait", 32'(WB_BusErr), 32'd0);
            check("to_wb_regwrite_wait", 32'(WB_RegWrite), 32'd0);
        end
        #1;
        check("to_abort_stall", 32'(mem_stall), 32'd0);
        tick();
        check("to_wb_buserr", 32'(WB_BusErr), 32'd1);
        check("to_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("to_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        set_op(32'h55, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0);
        tick();
        check("to_wb_buserr_clear", 32'(WB_BusErr), 32'd0);
        check("to_resume_data", WB_Data, 32'h55);
        check("to_resume_regwrite", 32'(WB_RegWrite), 32'd1);

        // Reset asserted mid-WAIT
        set_op(32'h5000, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
        #1;
        check("rw_stall", 32'(mem_stall), 32'd1);
        tick();
        check("rw_state_wait", 32'(dbg_state), 32'(ST_WAIT));
        reset = 1'b0;
        #1;
        check("rw_req_drop", 32'(bus.dmem_req), 32'd0);
        check("rw_stall_drop", 32'(mem_stall), 32'd0);
        check("rw_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("rw_wb_data", WB_Data, 32'd0);
        check("rw_wb_rd", 32'(WB_RD), 32'd0);
        check("rw_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        set_op(32'h5004, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0);
        bus.dmem_rdata = 32'h1234_5678;
        bus.dmem_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rw_new_req", 32'(bus.dmem_req), 32'd1);
        check("rw_new_stall", 32'(mem_stall), 32'd0);
        tick();
        check("rw_new_wb_data", WB_Data, 32'h1234_5678);
        check("rw_new_wb_rd", 32'(WB_RD), 32'd9);
        check("rw_new_wb_regwrite", 32'(WB_RegWrite), 32'd1);

        // LH with one wait cycle, then LBU issued directly after completion
        set_op(32'h6002, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, SZ_HALF, 1'b0);
        bus.dmem_rdata = 32'h8001_7FFF;
        bus.dmem_ready = 1'b0;
        #1;
        check("b2b_lh_stall", 32'(mem_stall), 32'd1);
        check("b2b_lh_be", 32'(bus.dmem_be), 32'hC);
        tick();
        bus.dmem_ready = 1'b1;
        #1;
        check("b2b_lh_done_stall", 32'(mem_stall), 32'd0);
        tick();
        check("b2b_lh_wb_data", WB_Data, 32'hFFFF_8001);
        check("b2b_lh_wb_regwrite", 32'(WB_RegWrite), 32'd1);
        set_op(32'h6001, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b1);
        bus.dmem_rdata = 32'h0000_AB00;
        #1;
        check("b2b_lbu_req", 32'(bus.dmem_req), 32'd1);
        check("b2b_lbu_stall", 32'(mem_stall), 32'd0);
        check("b2b_lbu_be", 32'(bus.dmem_be), 32'h2);
        tick();
        check("b2b_lbu_wb_data", WB_Data, 32'h0000_00AB);
        check("b2b_lbu_wb_rd", 32'(WB_RD), 32'd11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS MEM stage plus the MEM/WB pipeline register. It consumes the EX/MEM register outputs: ALU result/address, store data, destination register and control bits.
- Drives a variable-latency data-memory port with a req/ready handshake, with byte/half/word lane steering, load extension and alignment checking.
- Stalls upstream stages while an access is outstanding and registers write-back data for the WB stage.

Parameters:
- TIMEOUT, 16, cycles spent in WAIT before an access is aborted with a bus error (legal range 1..255).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- MEM_D1  in  32  ALU result; byte address for loads/stores.
- MEM_D2  in  32  store data (rt).
- MEM_RD  in  5  destination register.
- MEM_RegWrite  in  1  instruction writes a register.
- MEM_MemRead  in  1  load.
- MEM_MemWrite  in  1  store (MemRead and MemWrite are never both 1).
- MEM_Size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- MEM_Unsigned  in  1  zero-extend loads (LBU/LHU).
- dmem_req  out  1  access request.
- dmem_we  out  1  1=write.
- dmem_addr  out  32  word address {MEM_D1[31:2],2'b00}.
- dmem_be  out  4  byte enables, little-endian (bit0 = byte at addr[1:0]=0).
- dmem_wdata  out  32  store data replicated to lanes.
- dmem_rdata  in  32  read data, valid when dmem_ready=1.
- dmem_ready  in  1  access complete this cycle.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- WB_Data  out  32  write-back value.
- WB_RD  out  5  write-back register.
- WB_RegWrite  out  1  write-back enable.
- WB_Misalign  out  1  one-cycle flag: misaligned access.
- WB_BusErr  out  1  one-cycle flag: access timed out.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, and all WB_* outputs are 0.
- access = MemRead|MemWrite.
- misaligned = (half & D1[0]) | (word & D1[1:0]!=0).
- FSM states: IDLE, WAIT.
- IDLE:
  - If access and not misaligned: dmem_req=1 combinationally.
  - If dmem_ready=1 in the same cycle, the access completes with zero stall.
  - Otherwise mem_stall=1 and the next state is WAIT with counter=1.
- WAIT:
  - dmem_req=1; addr/be/we/wdata are recomputed from the inputs, which upstream holds stable because of the stall.
  - On dmem_ready=1: complete, next state IDLE, mem_stall=0.
  - Else if counter==TIMEOUT: abort, next state IDLE, mem_stall=0; the WB register captures WB_BusErr=1, WB_RegWrite=0.
  - Else counter+1 and mem_stall=1.
- mem_stall = dmem_req & ~dmem_ready & ~abort. It is purely combinational from state, inputs and dmem_ready.
- dmem_req must be 0 in IDLE for non-access or misaligned instructions.
- Store lanes:
  - byte: be=1<<a[1:0], wdata={4{D2[7:0]}}.
  - half: be=a[1]?4'b1100:4'b0011, wdata={2{D2[15:0]}}.
  - word: be=4'b1111, wdata=D2.
- Loads: dmem_be follows the same pattern as stores; dmem_wdata is don't-care.
- Load data: select the byte/half by a[1:0] from dmem_rdata, then sign-extend, or zero-extend when Unsigned=1.
- MEM/WB register, updated every rising edge:
  - Stalled cycle: bubble, i.e. WB_RegWrite=0 and both flags 0. WB_Data/WB_RD are don't-care but must not produce a write.
  - Completed load: WB_Data = extended load data.
  - Completed store: WB_RegWrite=0.
  - Non-access instruction: WB_Data=D1 and WB_RegWrite=MEM_RegWrite.
  - Misaligned: no request is issued, WB_RegWrite=0, WB_Misalign=1 for one cycle, no stall.
- Latency: one clock from completion to the WB_* outputs.
- A store that completes has already written memory. An abort leaves memory state undefined.
- Reset asserted mid-WAIT: dmem_req drops immediately (state IDLE) and there is no completion. The memory model must tolerate an abandoned request.
- Back-to-back accesses: a new request may issue in the IDLE cycle directly after a completion.

Decomposition:
- Shared package mips_pkg holds the size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the state encodings ST_IDLE/ST_WAIT.
- One natural sub-module, load_align: purely combinational rdata, a[1:0], size, unsigned -> 32-bit extended result.
- Store lane generation stays inline.

Test Plan:
- ALU op, D1=0x1234, RD=5, RegWrite=1 -> next cycle WB_Data=0x1234, WB_RD=5, WB_RegWrite=1, dmem_req never asserted.
- LB at 0x1003, rdata=0x80FF_FFFF, ready same cycle -> no stall, WB_Data=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH at 0x2002, D2=0xCAFE_BEEF, ready after 3 cycles -> mem_stall=1 for exactly 3 cycles, be=4'b1100, wdata=0xBEEF_BEEF, addr=0x2000, WB_RegWrite=0 throughout.
- LW at 0x3001 -> dmem_req=0, no stall, WB_Misalign=1 for exactly one cycle, WB_RegWrite=0.
- LW with ready held low, TIMEOUT=4 -> stall for 4 cycles, then WB_BusErr=1 for one cycle and the pipeline resumes.
- Reset pulled low during WAIT -> dmem_req=0 asynchronously and all WB_* outputs 0. After release, a new LW completes normally.
